// File: rtl/counter_pkg.sv
// Shared types and geometry constants for the kitchen counter controller.
package counter_pkg;

  // Items that can sit on a counter or in the penguin's hand.
  typedef enum logic [2:0] {
    EMPTY   = 3'd0,
    FISH    = 3'd1,
    RICE    = 3'd2,
    SEAWEED = 3'd3,
    SUSHI   = 3'd4,
    PLATE   = 3'd5
  } item_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DIVIDE = 3'd1,
    S_CHECK  = 3'd2,
    S_ACCESS = 3'd3,
    S_REJECT = 3'd4
  } state_t;

  // Counter geometry in screen pixels: counters are 40 px apart, the wall
  // blocks report a corner 20 px into the pitch, and the two rows sit at
  // fixed Y positions.
  localparam logic [9:0] COUNTER_PITCH  = 10'd40;
  localparam logic [9:0] COUNTER_OFFSET = 10'd20;
  localparam logic [9:0] ROW_Y_MID      = 10'd220;
  localparam logic [9:0] ROW_Y_BOT      = 10'd380;

  // Bottom-right counter, used as the bin when trash support is built in.
  localparam logic [4:0] TRASH_SLOT = 5'd31;

endpackage

// File: rtl/counter_slot_decode.sv
// Iterative coordinate-to-slot decoder. X is reduced by repeated subtraction
// of the counter pitch (one step per cycle while 'step' is high); the column
// is the number of subtractions. The owner FSM loads it with 'start', steps it
// until 'divdone' or 'err', then reads 'valid' and 'slot'.
import counter_pkg::*;

module counter_slot_decode #(
  parameter int MAX_COL = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       step,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic       divdone,
  output logic       err,
  output logic       valid,
  output logic [4:0] slot
);

  localparam logic [4:0] MAX_COL_W = 5'(MAX_COL);

  logic [9:0] rem;
  logic [4:0] col;
  logic [9:0] ylat;
  logic       row;

  // Latch the request coordinates, then subtract one pitch per step.
  // Stepping stops once the column has run past the last legal counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem  <= '0;
      col  <= '0;
      ylat <= '0;
    end else if (start) begin
      rem  <= x;
      col  <= '0;
      ylat <= y;
    end else if (step && (rem >= COUNTER_PITCH) && !err) begin
      rem <= rem - COUNTER_PITCH;
      col <= col + 5'd1;
    end
  end

  assign divdone = (rem < COUNTER_PITCH);
  assign err     = (col > MAX_COL_W);
  assign row     = (ylat == ROW_Y_BOT);
  assign valid   = (rem == COUNTER_OFFSET) &&
                   ((ylat == ROW_Y_MID) || (ylat == ROW_Y_BOT));
  assign slot    = {row, col[3:0]};

endmodule

// File: rtl/counter_interact.sv
// Pick-up/place controller for the kitchen counters. A fresh press of the
// interact key while touching a counter decodes the counter's slot and swaps
// the item between the penguin's hand and that slot. Owns the 32-entry item
// store read back by the renderer.
//
// Optional build macro: COUNTER_TRASH_EN -- slot {1,15} becomes a bin that
// swallows whatever is placed into it and never yields an item.
//
// The hook* ports are a direct store write used to preload counters for
// bring-up and test; tie hookWe low in normal use.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for a key edge while touching a counter
// S_DIVIDE | decoder reducing X to a column, one pitch per cycle
// S_CHECK  | decoder result checked for alignment and a legal row
// S_ACCESS | swap applied, done pulsed
// S_REJECT | request dropped, rejected pulsed
import counter_pkg::*;

module counter_interact #(
  parameter logic [7:0] KEY_INTERACT = 8'h2C,
  parameter int         MAX_COL      = 15
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic       touchingFlag,
  input  logic [9:0] nearestCounterX,
  input  logic [9:0] nearestCounterY,
  input  logic [4:0] rdSlot,
  input  logic       hookWe,
  input  logic [4:0] hookSlot,
  input  logic [2:0] hookItem,
  output logic [2:0] rdItem,
  output logic [2:0] heldItem,
  output logic       busy,
  output logic       done,
  output logic       rejected
);

  state_t     state;
  logic       prevKey;
  logic       keyNow;
  logic       keyHit;
  logic       start;
  logic       divdone;
  logic       err;
  logic       valid;
  logic [4:0] slot;
  logic [2:0] store [32];
  logic [2:0] slotItem;

  assign keyNow   = (keycode == KEY_INTERACT);
  assign keyHit   = keyNow && !prevKey;
  assign start    = (state == S_IDLE) && keyHit && touchingFlag;
  assign busy     = (state != S_IDLE);
  assign slotItem = store[slot];

  counter_slot_decode #(.MAX_COL(MAX_COL)) u_decode (
    .clk     (Clk),
    .rst     (Reset),
    .start   (start),
    .step    (state == S_DIVIDE),
    .x       (nearestCounterX),
    .y       (nearestCounterY),
    .divdone (divdone),
    .err     (err),
    .valid   (valid),
    .slot    (slot)
  );

  // Request sequencing, hand/store swap, renderer read port and pulses.
  // A swap in ACCESS overrides a preload to the same slot in that cycle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= S_IDLE;
      prevKey  <= 1'b0;
      heldItem <= '0;
      rdItem   <= '0;
      done     <= 1'b0;
      rejected <= 1'b0;
      for (int i = 0; i < 32; i++) store[i] <= '0;
    end else begin
      done     <= 1'b0;
      rejected <= 1'b0;
      prevKey  <= keyNow;
      rdItem   <= store[rdSlot];
      if (hookWe) store[hookSlot] <= hookItem;
      case (state)
        S_IDLE: begin
          if (start) state <= S_DIVIDE;
        end
        S_DIVIDE: begin
          if (err)          state <= S_REJECT;
          else if (divdone) state <= S_CHECK;
        end
        S_CHECK: begin
          state <= valid ? S_ACCESS : S_REJECT;
        end
        S_ACCESS: begin
`ifdef COUNTER_TRASH_EN
          if (slot == TRASH_SLOT) begin
            if (heldItem != EMPTY) begin
              heldItem    <= EMPTY;
              store[slot] <= EMPTY;
            end
          end else
`endif
          if ((heldItem == EMPTY) && (slotItem != EMPTY)) begin
            heldItem    <= slotItem;
            store[slot] <= EMPTY;
          end else if ((heldItem != EMPTY) && (slotItem == EMPTY)) begin
            store[slot] <= heldItem;
            heldItem    <= EMPTY;
          end
          done  <= 1'b1;
          state <= S_IDLE;
        end
        S_REJECT: begin
          rejected <= 1'b1;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
